id_free_list: RTL and testbench
===============================

Name: id_free_list

Overview:
- Hardware ID allocator that manages a pool of NUM_IDS tags, such as transaction IDs or buffer slots, shared between one allocating requester and one releasing requester.
- It keeps a per-ID busy vector.
- It finds the lowest-index free ID with a trailing-zero counter (an lzc instance in MODE 0, fed the inverted busy vector).
- Alloc and free are handshaked, and the block counts allocated IDs.
- It sits between a request issuer (alloc side) and a response/retire path (free side).

Parameters:
- NUM_IDS, 16: number of managed IDs; must be ≥2.
- IdWidth, $clog2(NUM_IDS): width of ID fields; derived, not to be overridden.
- CntWidth, $clog2(NUM_IDS+1): width of the occupancy count; derived.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous clear: release all IDs.
- alloc_req_i  input  1  requester wants an ID this cycle.
- alloc_gnt_o  output  1  ID granted this cycle; combinational from req and state.
- alloc_id_o  output  IdWidth  lowest free ID; valid when alloc_gnt_o=1.
- free_valid_i  input  1  release free_id_i this cycle; always accepted.
- free_id_i  input  IdWidth  ID to release.
- busy_o  output  NUM_IDS  registered busy vector; bit i=1 means ID i is allocated.
- count_o  output  CntWidth  registered number of allocated IDs.
- full_o  output  1  all IDs allocated; registered-derived.
- empty_o  output  1  no ID allocated; registered-derived.
- err_o  output  1  one-cycle registered pulse on an illegal free.

Behaviour:
- Reset (rst_ni=0, async): busy_q='0, count_q=0, err_q=0. Resulting outputs: full_o=0, empty_o=1, alloc_gnt_o=alloc_req_i.
- Free-ID search: the lzc input is ~busy_q.
  - alloc_id_o = cnt_o.
  - full_o = lzc empty_o, equivalently &busy_q.
  - When full, alloc_id_o = NUM_IDS-1 (lzc all-zero value); the value is not meaningful.
- Grant: alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i. It depends only on registered state, so there is no combinational path from free_* to alloc_*.
- A granted ID sets busy_q[alloc_id_o] at the next edge.
- Latency: the next ID is visible one cycle after a grant. Back-to-back grants return consecutive lowest-free IDs.
- Legal free: free_valid_i=1, free_id_i<NUM_IDS and busy_q[free_id_i]=1. Effect: busy_q[free_id_i] clears at the next edge.
- A freed ID becomes allocatable the cycle after the free. No same-cycle bypass.
- Illegal free: free_id_i≥NUM_IDS, or the ID is not busy (double free). State is unchanged and err_q=1 for exactly the next cycle.
- Simultaneous alloc grant and legal free in the same cycle: both take effect and count_q is unchanged.
  - They can never target the same ID, because a granted ID is free and a legal free ID is busy.
- A free in a cycle when full_o=1 does not enable a grant in that same cycle.
- count_q update: next = count_q + gnt − legal_free. It never wraps; it stays within 0..NUM_IDS.
- empty_o = (count_q==0). Invariant: count_q == popcount(busy_q).
- flush_i=1 has priority over alloc and free:
  - next busy_q='0, count_q=0, err_q=0;
  - alloc_gnt_o forced 0;
  - free_* ignored, with no error.
- Reset mid-operation: immediate asynchronous return to reset values. Outstanding IDs are forgotten.
- Assertions (sim only):
  - NUM_IDS≥2.
  - count_q==popcount(busy_q).
  - alloc_gnt_o implies ~busy_q[alloc_id_o].

Test Plan:
- Reset, then alloc_req_i=1 for 4 cycles (NUM_IDS=16) → grants IDs 0,1,2,3; count_o=4, busy_o=16'h000F, empty_o=0.
- From busy=16'h000F: free ID 1, next cycle alloc → the free cycle grants ID 4 (1 not yet visible). The following grant returns ID 1, and busy_o=16'h001F.
- Alloc 16 times → full_o=1 after the 16th grant and alloc_gnt_o=0 with req held. Then free ID 7 → next cycle grant ID 7 and full_o=1 again.
- Simultaneous alloc grant (ID 5) and legal free of ID 2 with count 5 → count_o stays 5, busy bit 5 set, bit 2 cleared.
- Free ID 9 while it is not busy, and free ID 20 with NUM_IDS=20 and IdWidth=5 → err_o pulses high one cycle each; busy_o and count_o unchanged.
- With 6 IDs allocated, assert flush_i together with alloc_req_i and free_valid_i → alloc_gnt_o=0 and err_o stays 0. Next cycle busy_o='0, count_o=0, empty_o=1, and the next alloc grants ID 0. Repeat with rst_ni pulsed low mid-burst → outputs reset asynchronously.

Source files
------------

// File: rtl/id_free_list_if.sv
// Alloc/free handshake and status bundle between the ID pool and its users.
interface id_free_list_if #(
    parameter int NUM_IDS = 16
);
    localparam int IdWidth  = $clog2(NUM_IDS);
    localparam int CntWidth = $clog2(NUM_IDS + 1);

    logic                flush;
    logic                alloc_req;
    logic                alloc_gnt;
    logic [IdWidth-1:0]  alloc_id;
    logic                free_valid;
    logic [IdWidth-1:0]  free_id;
    logic [NUM_IDS-1:0]  busy;
    logic [CntWidth-1:0] count;
    logic                full;
    logic                empty;
    logic                err;

    modport master (
        output flush, alloc_req, free_valid, free_id,
        input  alloc_gnt, alloc_id, busy, count, full, empty, err
    );

    modport slave (
        input  flush, alloc_req, free_valid, free_id,
        output alloc_gnt, alloc_id, busy, count, full, empty, err
    );
endinterface

// File: rtl/id_free_list.sv
// ID pool allocator: grants lowest free ID combinationally, state updates one edge later.
// Frees are always accepted; alloc is withheld while full or flushing.
module id_free_list_lzc #(
    parameter int WIDTH = 16,
    parameter bit MODE  = 1'b0,
    localparam int CntW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] in_sel;

    always_comb begin
        in_sel = in_i;
        if (MODE) begin
            for (int i = 0; i < WIDTH; i++) in_sel[i] = in_i[WIDTH-1-i];
        end
    end

    // Scan from the top so the lowest set bit wins; all-zero input yields WIDTH-1.
    always_comb begin
        cnt_o = CntW'(WIDTH - 1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_sel[i]) cnt_o = CntW'(i);
        end
    end

    assign empty_o = ~|in_i;
endmodule

module id_free_list #(
    parameter int NUM_IDS = 16,
    localparam int IdWidth  = $clog2(NUM_IDS),
    localparam int CntWidth = $clog2(NUM_IDS + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    id_free_list_if.slave bus
);
    generate
        if (NUM_IDS < 2) begin : g_bad_num_ids
            $error("id_free_list: NUM_IDS must be at least 2");
        end
    endgenerate

    logic [NUM_IDS-1:0]      busy_q, busy_d;
    logic [CntWidth-1:0]     count_q, count_d;
    logic                    err_q, err_d;
    logic [IdWidth-1:0]      free_idx;
    logic                    full;
    logic                    gnt;
    logic                    legal_free;
    logic [(2**IdWidth)-1:0] busy_ext;
    logic [NUM_IDS-1:0]      gnt_mask, free_mask;

    id_free_list_lzc #(
        .WIDTH (NUM_IDS),
        .MODE  (1'b0)
    ) u_lzc (
        .in_i    (~busy_q),
        .cnt_o   (free_idx),
        .empty_o (full)
    );

    // Out-of-range IDs map onto zero padding, so they read as not busy and fail legality.
    always_comb begin
        busy_ext              = '0;
        busy_ext[NUM_IDS-1:0] = busy_q;
    end

    assign gnt        = bus.alloc_req & ~full & ~bus.flush;
    assign legal_free = bus.free_valid & busy_ext[bus.free_id];
    assign gnt_mask   = NUM_IDS'(gnt) << free_idx;
    assign free_mask  = NUM_IDS'(legal_free) << bus.free_id;

    always_comb begin
        busy_d  = (busy_q | gnt_mask) & ~free_mask;
        count_d = count_q + CntWidth'(gnt) - CntWidth'(legal_free);
        err_d   = bus.free_valid & ~legal_free;
        if (bus.flush) begin
            busy_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.alloc_gnt = gnt;
    assign bus.alloc_id  = free_idx;
    assign bus.busy      = busy_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = (count_q == '0);
    assign bus.err       = err_q;

    a_count_matches_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q == CntWidth'($countones(busy_q)));

    a_gnt_targets_free_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        gnt |-> !busy_q[free_idx]);
endmodule

// File: tb/tb_id_free_list.sv
// Directed bench for id_free_list: a 16-ID pool and a 20-ID pool for out-of-range frees.
module tb_id_free_list;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_free_list_if #(.NUM_IDS(16)) a_if ();
    id_free_list_if #(.NUM_IDS(20)) b_if ();

    id_free_list #(.NUM_IDS(16)) u_dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave));
    id_free_list #(.NUM_IDS(20)) u_dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a_if.flush = 1'b0; a_if.alloc_req = 1'b0; a_if.free_valid = 1'b0; a_if.free_id = '0;
        b_if.flush = 1'b0; b_if.alloc_req = 1'b0; b_if.free_valid = 1'b0; b_if.free_id = '0;

        #12;
        check("rst_busy",  32'(a_if.busy), 32'h0);
        check("rst_count", 32'(a_if.count), 32'd0);
        check("rst_full",  32'(a_if.full), 32'd0);
        check("rst_empty", 32'(a_if.empty), 32'd1);
        check("rst_err",   32'(a_if.err), 32'd0);
        a_if.alloc_req = 1'b1;
        #1;
        check("rst_gnt_follows_req", 32'(a_if.alloc_gnt), 32'd1);
        a_if.alloc_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Four back-to-back grants return 0..3.
        a_if.alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("burst_gnt", 32'(a_if.alloc_gnt), 32'd1);
            check("burst_id",  32'(a_if.alloc_id), 32'(i));
            cyc();
        end
        a_if.alloc_req = 1'b0;
        #1;
        check("burst_count", 32'(a_if.count), 32'd4);
        check("burst_busy",  32'(a_if.busy), 32'h000F);
        check("burst_empty", 32'(a_if.empty), 32'd0);

        // Free 1 while allocating: the freed ID is not visible in the same cycle.
        a_if.alloc_req = 1'b1; a_if.free_valid = 1'b1; a_if.free_id = 4'd1;
        #1;
        check("nobypass_id", 32'(a_if.alloc_id), 32'd4);
        cyc();
        a_if.free_valid = 1'b0;
        #1;
        check("reuse_gnt", 32'(a_if.alloc_gnt), 32'd1);
        check("reuse_id",  32'(a_if.alloc_id), 32'd1);
        cyc();
        a_if.alloc_req = 1'b0;
        #1;
        check("reuse_busy",  32'(a_if.busy), 32'h001F);
        check("reuse_count", 32'(a_if.count), 32'd5);

        // Grant ID 5 and free ID 2 together: count holds at 5.
        a_if.alloc_req = 1'b1; a_if.free_valid = 1'b1; a_if.free_id = 4'd2;
        #1;
        check("simul_id", 32'(a_if.alloc_id), 32'd5);
        cyc();
        a_if.alloc_req = 1'b0; a_if.free_valid = 1'b0;
        #1;
        check("simul_count", 32'(a_if.count), 32'd5);
        check("simul_busy",  32'(a_if.busy), 32'h003B);

        // Double free of ID 9 raises a single-cycle error and leaves state alone.
        a_if.free_valid = 1'b1; a_if.free_id = 4'd9;
        cyc();
        a_if.free_valid = 1'b0;
        #1;
        check("dfree_err",   32'(a_if.err), 32'd1);
        check("dfree_busy",  32'(a_if.busy), 32'h003B);
        check("dfree_count", 32'(a_if.count), 32'd5);
        cyc();
        check("dfree_err_clear", 32'(a_if.err), 32'd0);

        // Fill the pool: remaining free IDs are 2, 6..15.
        a_if.alloc_req = 1'b1;
        #1;
        check("fill_first_id", 32'(a_if.alloc_id), 32'd2);
        for (int i = 0; i < 11; i++) begin
            check("fill_gnt", 32'(a_if.alloc_gnt), 32'd1);
            cyc();
        end
        #1;
        check("full_flag",  32'(a_if.full), 32'd1);
        check("full_count", 32'(a_if.count), 32'd16);
        check("full_busy",  32'(a_if.busy), 32'hFFFF);
        check("full_gnt",   32'(a_if.alloc_gnt), 32'd0);
        check("full_id",    32'(a_if.alloc_id), 32'd15);
        a_if.free_valid = 1'b1; a_if.free_id = 4'd7;
        #1;
        check("full_free_no_gnt", 32'(a_if.alloc_gnt), 32'd0);
        cyc();
        a_if.free_valid = 1'b0;
        #1;
        check("refill_full", 32'(a_if.full), 32'd0);
        check("refill_gnt",  32'(a_if.alloc_gnt), 32'd1);
        check("refill_id",   32'(a_if.alloc_id), 32'd7);
        cyc();
        a_if.alloc_req = 1'b0;
        #1;
        check("refill_full_again", 32'(a_if.full), 32'd1);
        check("refill_count",      32'(a_if.count), 32'd16);

        // Flush, allocate six, then flush again with alloc and an illegal free.
        a_if.flush = 1'b1;
        cyc();
        a_if.flush = 1'b0;
        a_if.alloc_req = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        #1;
        check("pre_flush_count", 32'(a_if.count), 32'd6);
        a_if.flush = 1'b1; a_if.free_valid = 1'b1; a_if.free_id = 4'd12;
        #1;
        check("flush_gnt", 32'(a_if.alloc_gnt), 32'd0);
        cyc();
        a_if.flush = 1'b0; a_if.free_valid = 1'b0;
        #1;
        check("flush_busy",  32'(a_if.busy), 32'h0);
        check("flush_count", 32'(a_if.count), 32'd0);
        check("flush_empty", 32'(a_if.empty), 32'd1);
        check("flush_err",   32'(a_if.err), 32'd0);
        check("flush_next_id", 32'(a_if.alloc_id), 32'd0);
        cyc();
        cyc();
        cyc();
        #1;
        check("preRst_count", 32'(a_if.count), 32'd3);

        // Asynchronous reset mid-burst, observed before the next edge.
        rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(a_if.busy), 32'h0);
        check("arst_count", 32'(a_if.count), 32'd0);
        check("arst_empty", 32'(a_if.empty), 32'd1);
        a_if.alloc_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        a_if.alloc_req = 1'b1;
        #1;
        check("post_rst_id", 32'(a_if.alloc_id), 32'd0);
        cyc();
        a_if.alloc_req = 1'b0;
        #1;
        check("post_rst_count", 32'(a_if.count), 32'd1);

        // 20-ID pool: freeing ID 20 is out of range.
        b_if.alloc_req = 1'b1;
        cyc();
        cyc();
        b_if.alloc_req = 1'b0;
        b_if.free_valid = 1'b1; b_if.free_id = 5'd20;
        cyc();
        b_if.free_valid = 1'b0;
        #1;
        check("oor_err",   32'(b_if.err), 32'd1);
        check("oor_busy",  32'(b_if.busy), 32'h3);
        check("oor_count", 32'(b_if.count), 32'd2);
        cyc();
        check("oor_err_clear", 32'(b_if.err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
